// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin burst arbiter for the fifo push port (optional FIFO_ARB_PRIO_EN)
module fifo_push_arbiter #(
  parameter int XLEN      = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0]      req_last_i,
  input  logic [NUM_REQ*XLEN-1:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_push_en_o,
  output logic [XLEN-1:0]         fifo_data_o,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic                    busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W:0]     w_idx;
  logic               w_found;
  logic               w_accept;
  logic               w_release;
  logic [PTR_W-1:0]   w_owner_inc;

  // Pick the first valid requester at or after rr_ptr, wrapping; requester 0 may pre-empt
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NUM_REQ)) w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
      if (!w_found && req_valid_i[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PTR_W-1:0];
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid_i[0]) begin
      w_found = 1'b1;
      w_sel   = '0;
    end
`endif
  end

  // Datapath toward the fifo: only the owner may push, and never into a full fifo
  always_comb begin
    req_ready_o    = '0;
    fifo_push_en_o = 1'b0;
    fifo_data_o    = '0;
    w_accept       = 1'b0;
    if (r_state == S_BURST && !rst_i) begin
      w_accept             = ~fifo_full_i & req_valid_i[r_owner];
      req_ready_o[r_owner] = w_accept;
      fifo_push_en_o       = w_accept;
      if (w_accept) fifo_data_o = req_data_i[int'(r_owner)*XLEN +: XLEN];
    end
  end

  assign w_owner_inc = (r_owner == PTR_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;
  assign w_release   = !req_valid_i[r_owner] ||
                       (w_accept && (req_last_i[r_owner] || r_beat_cnt == CNT_W'(MAX_BURST-1)));

  // Next-state logic: grant in IDLE, count beats and decide release in BURST
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_BURST;
          w_grant_nxt    = NUM_REQ'(1) << w_sel;
          w_owner_nxt    = w_sel;
          w_beat_cnt_nxt = '0;
        end
      end
      S_BURST: begin
        if (w_accept) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        if (w_release) begin
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_beat_cnt_nxt = '0;
          w_rr_ptr_nxt   = w_owner_inc;
`ifdef FIFO_ARB_PRIO_EN
          if (r_owner == '0) w_rr_ptr_nxt = r_rr_ptr;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any burst in progress
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign grant_o = r_grant;
  assign busy_o  = (r_state == S_BURST);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - directed vector bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   req_valid_i = '0;
  logic [3:0]   req_last_i = '0;
  logic [127:0] req_data_i = '0;
  logic [3:0]   req_ready_o;
  logic         fifo_full_i = 1'b0;
  logic         fifo_push_en_o;
  logic [31:0]  fifo_data_o;
  logic [3:0]   grant_o;
  logic         busy_o;

  int checks = 0;
  int failures = 0;

  fifo_push_arbiter #(.XLEN(32), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .fifo_full_i(fifo_full_i),
    .fifo_push_en_o(fifo_push_en_o), .fifo_data_o(fifo_data_o),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] dat;
    logic [3:0]  e_grant;
    logic [3:0]  e_ready;
    logic        e_push;
    logic [31:0] e_data;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(logic rst, logic [3:0] valid, logic [3:0] last, logic full,
                            logic [31:0] dat, logic [3:0] g, logic [3:0] r, logic p,
                            logic [31:0] d, logic b);
    vec_t x;
    x.rst = rst; x.valid = valid; x.last = last; x.full = full; x.dat = dat;
    x.e_grant = g; x.e_ready = r; x.e_push = p; x.e_data = d; x.e_busy = b;
    vecs.push_back(x);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [3:0] valid, logic [3:0] last, logic full, logic [31:0] dat);
    rst_i       = rst;
    req_valid_i = valid;
    req_last_i  = last;
    fifo_full_i = full;
    for (int n = 0; n < 4; n++) req_data_i[n*32 +: 32] = dat + 32'(n);
  endtask

  task automatic check_all(int idx, logic [3:0] g, logic [3:0] r, logic p, logic [31:0] d, logic b);
    chk("grant", idx, {28'd0, grant_o}, {28'd0, g});
    chk("ready", idx, {28'd0, req_ready_o}, {28'd0, r});
    chk("push", idx, {31'd0, fifo_push_en_o}, {31'd0, p});
    chk("data", idx, fifo_data_o, d);
    chk("busy", idx, {31'd0, busy_o}, {31'd0, b});
  endtask

  initial begin
    // reset with all requesters valid
    v(1, 4'b1111, 4'b0000, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0, 0);
    v(1, 4'b1111, 4'b1111, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0, 0);
    // single beat from requester 2
    v(0, 4'b0100, 4'b0100, 0, 32'hA5A5_0000, 4'b0000, 4'b0000, 0, 32'h0, 0);
    v(0, 4'b0100, 4'b0100, 0, 32'hA5A5_0000, 4'b0100, 4'b0100, 1, 32'hA5A5_0002, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0, 0);
    // round robin from rr_ptr=3: 3,0,1,2,3
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b0000, 4'b0000, 0, 32'h0, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b1000, 4'b1000, 1, 32'h103, 1);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b0000, 4'b0000, 0, 32'h0, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b0001, 4'b0001, 1, 32'h100, 1);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b0000, 4'b0000, 0, 32'h0, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b0010, 4'b0010, 1, 32'h101, 1);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b0000, 4'b0000, 0, 32'h0, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b0100, 4'b0100, 1, 32'h102, 1);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b0000, 4'b0000, 0, 32'h0, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h100, 4'b1000, 4'b1000, 1, 32'h103, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h0,   4'b0000, 4'b0000, 0, 32'h0, 0);
    // burst cap: requester 1, six beats 0x10..0x15
    v(0, 4'b0010, 4'b0000, 0, 32'h0F, 4'b0000, 4'b0000, 0, 32'h0,  0);
    v(0, 4'b0010, 4'b0000, 0, 32'h0F, 4'b0010, 4'b0010, 1, 32'h10, 1);
    v(0, 4'b0010, 4'b0000, 0, 32'h10, 4'b0010, 4'b0010, 1, 32'h11, 1);
    v(0, 4'b0010, 4'b0000, 0, 32'h11, 4'b0010, 4'b0010, 1, 32'h12, 1);
    v(0, 4'b0010, 4'b0000, 0, 32'h12, 4'b0010, 4'b0010, 1, 32'h13, 1);
    v(0, 4'b0010, 4'b0000, 0, 32'h13, 4'b0000, 4'b0000, 0, 32'h0,  0);
    v(0, 4'b0010, 4'b0000, 0, 32'h13, 4'b0010, 4'b0010, 1, 32'h14, 1);
    v(0, 4'b0010, 4'b0010, 0, 32'h14, 4'b0010, 4'b0010, 1, 32'h15, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h0,  4'b0000, 4'b0000, 0, 32'h0,  0);
    // full stall on requester 3
    v(0, 4'b1000, 4'b1000, 1, 32'hDEAD_BEEC, 4'b0000, 4'b0000, 0, 32'h0, 0);
    v(0, 4'b1000, 4'b1000, 1, 32'hDEAD_BEEC, 4'b1000, 4'b0000, 0, 32'h0, 1);
    v(0, 4'b1000, 4'b1000, 1, 32'hDEAD_BEEC, 4'b1000, 4'b0000, 0, 32'h0, 1);
    v(0, 4'b1000, 4'b1000, 0, 32'hDEAD_BEEC, 4'b1000, 4'b1000, 1, 32'hDEAD_BEEF, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000, 0, 32'h0, 0);
    // idle release: requester 0 drops valid while granted
    v(0, 4'b0001, 4'b0000, 0, 32'h50, 4'b0000, 4'b0000, 0, 32'h0, 0);
    v(0, 4'b0000, 4'b0000, 0, 32'h50, 4'b0001, 4'b0000, 0, 32'h0, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h50, 4'b0000, 4'b0000, 0, 32'h0, 0);
    // requesters 0 and 2 contend with rr_ptr=1
`ifdef FIFO_ARB_PRIO_EN
    v(0, 4'b0101, 4'b0101, 0, 32'h200, 4'b0000, 4'b0000, 0, 32'h0,   0);
    v(0, 4'b0101, 4'b0101, 0, 32'h200, 4'b0001, 4'b0001, 1, 32'h200, 1);
    v(0, 4'b0100, 4'b0100, 0, 32'h200, 4'b0000, 4'b0000, 0, 32'h0,   0);
    v(0, 4'b0100, 4'b0100, 0, 32'h200, 4'b0100, 4'b0100, 1, 32'h202, 1);
`else
    v(0, 4'b0101, 4'b0101, 0, 32'h200, 4'b0000, 4'b0000, 0, 32'h0,   0);
    v(0, 4'b0101, 4'b0101, 0, 32'h200, 4'b0100, 4'b0100, 1, 32'h202, 1);
    v(0, 4'b0001, 4'b0001, 0, 32'h200, 4'b0000, 4'b0000, 0, 32'h0,   0);
    v(0, 4'b0001, 4'b0001, 0, 32'h200, 4'b0001, 4'b0001, 1, 32'h200, 1);
`endif
    v(0, 4'b0000, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000, 0, 32'h0, 0);

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].full, vecs[i].dat);
      #1;
      check_all(i, vecs[i].e_grant, vecs[i].e_ready, vecs[i].e_push, vecs[i].e_data, vecs[i].e_busy);
    end

    // reset in the middle of a burst: aborts it and returns rr_ptr to 0
    @(negedge clk_i);
    drive(0, 4'b0010, 4'b0000, 0, 32'h300);
    @(negedge clk_i);
    #1;
    check_all(100, 4'b0010, 4'b0010, 1, 32'h301, 1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_all(101, 4'b0000, 4'b0000, 0, 32'h0, 0);
    @(negedge clk_i);
    drive(0, 4'b1111, 4'b0000, 0, 32'h300);
    #1;
    check_all(102, 4'b0000, 4'b0000, 0, 32'h0, 0);
    @(negedge clk_i);
    #1;
    check_all(103, 4'b0001, 4'b0001, 1, 32'h300, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
